// File: rtl/axi_sram_rd_slave_if.sv
// AXI4 read-address / read-data channel bundle between a burst reader (master)
// and the SRAM read responder (slave).
interface axi_sram_rd_slave_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_sram_rd_slave.sv
// AXI4 read responder over a 32-bit word SRAM with FIXED/INCR/WRAP bursts and backdoor preload.
// Define SRAM_RD_LAT_EN to insert LATENCY idle cycles before the first beat of each burst.
module axi_sram_rd_slave #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_sram_rd_slave_if.slave   io_slave,
  input  logic                 bd_wen,
  input  logic [31:0]          bd_waddr,
  input  logic [31:0]          bd_wdata
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  if ((LATENCY < 1) || (LATENCY > 255) || (DEPTH != (1 << AW))) begin : g_bad_cfg
    $error("axi_sram_rd_slave: LATENCY must be 1..255 and DEPTH a power of two");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1
`ifdef SRAM_RD_LAT_EN
    , LAT = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
`ifdef SRAM_RD_LAT_EN
  logic [7:0]  lat_q, lat_d;
`endif
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic        arready_q, arready_d;

  logic [31:0] mem [DEPTH];

  // Unsigned offset compare also rejects addresses below BASE (they wrap high).
  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  function automatic logic [1:0] beat_resp(input logic [2:0] sz, input logic [31:0] a);
    if (sz > 3'd2)    return 2'b10;
    if (!in_range(a)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] sz, input logic [1:0] bu);
    logic [31:0] nxt, win;
    logic        wrap_ok;
    nxt     = a + (32'd1 << sz);
    win     = ({24'd0, len} + 32'd1) << sz;
    wrap_ok = (bu == 2'b10) &&
              ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    if (bu == 2'b00) return a;
    if (wrap_ok)     return (a & ~(win - 32'd1)) | (nxt & (win - 32'd1));
    return nxt;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
`ifdef SRAM_RD_LAT_EN
    lat_d   = lat_q;
`endif
    case (state_q)
      IDLE: begin
        if (io_slave.arvalid && arready_q) begin
          addr_d  = io_slave.araddr;
          id_d    = io_slave.arid;
          len_d   = io_slave.arlen;
          size_d  = io_slave.arsize;
          burst_d = io_slave.arburst;
          beat_d  = 8'd0;
`ifdef SRAM_RD_LAT_EN
          lat_d   = 8'(LATENCY - 1);
          state_d = LAT;
`else
          state_d = BEAT;
`endif
        end
      end
`ifdef SRAM_RD_LAT_EN
      LAT: begin
        if (lat_q == 8'd0) state_d = BEAT;
        else               lat_d   = lat_q - 8'd1;
      end
`endif
      BEAT: begin
        if (rvalid_q && io_slave.rready) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = next_addr(addr_q, len_q, size_q, burst_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rvalid_d  = (state_d == BEAT);
    rlast_d   = (state_d == BEAT) && (beat_d == len_d);
    arready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
`ifdef SRAM_RD_LAT_EN
      lat_q     <= '0;
`endif
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
`ifdef SRAM_RD_LAT_EN
      lat_q     <= lat_d;
`endif
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      arready_q <= arready_d;
    end
  end

  // Backdoor writes land at the edge, so a presented beat shows new data the next cycle.
  always_ff @(posedge clock) begin
    if (bd_wen && (bd_waddr[1:0] == 2'b00) && in_range(bd_waddr))
      mem[word_idx(bd_waddr)] <= bd_wdata;
  end

  assign io_slave.arready = arready_q;
  assign io_slave.rvalid  = rvalid_q;
  assign io_slave.rlast   = rlast_q;
  assign io_slave.rid     = id_q;
  assign io_slave.rresp   = rvalid_q ? beat_resp(size_q, addr_q) : 2'b00;
  assign io_slave.rdata   = (rvalid_q && in_range(addr_q)) ? mem[word_idx(addr_q)] : 32'd0;

endmodule

// File: doc/axi_sram_rd_slave.md
# axi_sram_rd_slave

AXI4 read-channel responder backed by a 32-bit-word SRAM model; the slave end of the AR/R interface driven by the fetch-stage burst reader and the LSU read path. It accepts one address request at a time, returns INCR/FIXED/WRAP bursts beat by beat under `rready` backpressure, and flags bad sizes and out-of-range addresses in `rresp`. A backdoor write port preloads images for simulation.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words (power of two).
- `BASE`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 4: idle cycles before first R beat (only with `SRAM_RD_LAT_EN`); legal 1..255.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_slave_arvalid`  in  1  request valid.
- `io_slave_arready`  out  1  request accepted.
- `io_slave_araddr`  in  32  burst start byte address.
- `io_slave_arid`  in  4  transaction ID.
- `io_slave_arlen`  in  8  beats minus one.
- `io_slave_arsize`  in  3  bytes per beat = 1<<arsize.
- `io_slave_arburst`  in  2  00 FIXED, 01 INCR, 10 WRAP.
- `io_slave_rvalid`  out  1  beat valid.
- `io_slave_rready`  in  1  master accepts beat.
- `io_slave_rdata`  out  32  beat data.
- `io_slave_rresp`  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- `io_slave_rlast`  out  1  final beat.
- `io_slave_rid`  out  4  echo of captured arid.
- `bd_wen`  in  1  backdoor write enable.
- `bd_waddr`  in  32  backdoor byte address (word-aligned, in range; others ignored).
- `bd_wdata`  in  32  backdoor data.

## Operation
- FSM states: IDLE, LAT (only with macro), BEAT.
- IDLE: `arready`=1; on `arvalid && arready` capture addr/id/len/size/burst, clear beat counter, go BEAT (or LAT with counter loaded to LATENCY-1).
- LAT: count down each cycle; at zero go BEAT. `rvalid`=0.
- BEAT: `rvalid`=1; `rlast` = (beat_cnt == len). On `rvalid && rready`: if rlast go IDLE, else beat_cnt+1 and advance address.
- Address advance: FIXED holds; INCR adds 1<<size; WRAP adds 1<<size then wraps within aligned window of (len+1)<<size bytes (len must be 1,3,7,15; other len with WRAP treated as INCR).
- `rdata` = mem[(addr-BASE)>>2] when valid and in range, else 0; byte lanes not narrowed for sub-word sizes.
- `rresp`: SLVERR for every beat if size>2; else DECERR for a beat whose address is outside [BASE, BASE+4*DEPTH); else OKAY. Error beats still count; burst always completes len+1 beats.
- `rid` = captured arid, held for whole burst.
- Backdoor write updates array at clock edge, independent of FSM.

## Timing
- Reset (async, `reset`=0): state IDLE, counters 0, captured fields 0; `arready`=0 while reset low, `rvalid`/`rlast`=0, `rdata`/`rresp`/`rid`=0. Reset mid-burst abandons it; `rvalid` drops immediately.
- Without macro: AR handshake at edge N -> beat 0 valid in cycle N+1.
- Beat held stable (data, resp, last, id) until accepted; `rready` low stalls indefinitely.
- Last-beat handshake at edge M -> `arready`=1 in cycle M+1; minimum one idle cycle between bursts (arlen=0 burst occupies 2 cycles).
- `arready`=0 in LAT and BEAT; `arvalid` there is ignored.
- Backdoor write to word being presented: old data this cycle, new data from next cycle.

## Configuration
- `SRAM_RD_LAT_EN` defined: LAT state present; first beat at N+LATENCY+1 after AR handshake; subsequent beats unaffected.
- Undefined: no LAT state or counter; first beat at N+1.

## Test plan
- Preload words 0..3 = 11,22,33,44; AR addr 0x8000_0000 len 3 size 2 INCR id 5, rready=1 -> beats 11,22,33,44 on consecutive cycles, rlast on 4th, rid 5, rresp 00.
- WRAP len 3 addr 0x8000_0008 -> data 33,44,11,22.
- Same INCR burst with rready toggling 1/0 -> each beat held while rready=0, no beat dropped or repeated.
- AR addr 0x7FFF_FFFC len 1 -> beat0 rresp 11 rdata 0, beat1 rresp 00 rdata 11; AR size 3 -> all beats rresp 10.
- Assert reset low during beat 2 -> rvalid 0 immediately; after release new burst returns beat 0 correctly.
- With `SRAM_RD_LAT_EN`, LATENCY=4: first rvalid exactly 5 cycles after AR handshake.
